// File: rtl/bram_port_arbiter_pkg.sv
// Shared constants and bus-packing helpers for the BRAM port arbiter.
package bram_port_arbiter_pkg;

  localparam int unsigned BRAM_LAT_LOW  = 1;
  localparam int unsigned BRAM_LAT_HIGH = 2;

endpackage

// Select field idx of width w from a flat packed vector.
`define BPA_FIELD(vec, idx, w) vec[(idx)*(w) +: (w)]

// File: rtl/rr_priority_picker.sv
// Combinational round-robin picker: first set request after last_grant wins.
module rr_priority_picker
  import bram_port_arbiter_pkg::*;
#(
  parameter int unsigned N_REQ = 4,
  parameter int unsigned IDX_W = $clog2(N_REQ)
) (
  input  logic [N_REQ-1:0] req,
  input  logic [IDX_W-1:0] last_grant,
  output logic [N_REQ-1:0] grant,
  output logic [IDX_W-1:0] grant_idx
);

  logic        found;
  int unsigned cand;

  // Walk the ring starting one past the previous winner.
  always_comb begin
    grant     = '0;
    grant_idx = '0;
    found     = 1'b0;
    cand      = 0;
    for (int unsigned k = 1; k <= N_REQ; k++) begin
      cand = (32'(last_grant) + k) % N_REQ;
      if (!found && req[IDX_W'(cand)]) begin
        found                 = 1'b1;
        grant[IDX_W'(cand)]   = 1'b1;
        grant_idx             = IDX_W'(cand);
      end
    end
  end

endmodule

// File: rtl/bram_port_arbiter.sv
// Round-robin arbiter sharing one read-first BRAM port; a one-hot tag pipeline
// matched to the RAM read latency steers each read response to its requester.
module bram_port_arbiter
  import bram_port_arbiter_pkg::*;
#(
  parameter int unsigned N_REQ        = 4,
  parameter int unsigned DATA_W       = 18,
  parameter int unsigned ADDR_W       = 10,
  parameter int unsigned READ_LATENCY = BRAM_LAT_HIGH
) (
  input  logic                      clk_in,
  input  logic                      rst_in,
  input  logic [N_REQ-1:0]          req_valid_in,
  input  logic [N_REQ-1:0]          req_we_in,
  input  logic [N_REQ*ADDR_W-1:0]   req_addr_in,
  input  logic [N_REQ*DATA_W-1:0]   req_data_in,
  output logic [N_REQ-1:0]          req_ready_out,
  output logic [N_REQ-1:0]          rsp_valid_out,
  output logic [DATA_W-1:0]         rsp_data_out,
  output logic                      ram_en_out,
  output logic                      ram_we_out,
  output logic [ADDR_W-1:0]         ram_addr_out,
  output logic [DATA_W-1:0]         ram_din_out,
  output logic                      ram_regce_out,
  input  logic [DATA_W-1:0]         ram_dout_in
);

  localparam int unsigned IDX_W = $clog2(N_REQ);

  if (N_REQ < 2 || READ_LATENCY < BRAM_LAT_LOW) begin : g_bad_cfg
    $error("bram_port_arbiter: unsupported N_REQ or READ_LATENCY");
  end

  logic [IDX_W-1:0]  last_grant;
  logic [IDX_W-1:0]  win_idx;
  logic [N_REQ-1:0]  grant;
  logic [N_REQ-1:0]  rd_tag;
  logic              xfer;
  logic              win_we;
  logic [ADDR_W-1:0] win_addr;
  logic [DATA_W-1:0] win_data;
  logic [N_REQ-1:0]  tag_pipe [READ_LATENCY];

  rr_priority_picker #(
    .N_REQ (N_REQ),
    .IDX_W (IDX_W)
  ) u_picker (
    .req        (req_valid_in),
    .last_grant (last_grant),
    .grant      (grant),
    .grant_idx  (win_idx)
  );

  // Grant and RAM request mux; everything is forced idle while in reset.
  always_comb begin
    req_ready_out = '0;
    xfer          = 1'b0;
    win_we        = 1'b0;
    win_addr      = '0;
    win_data      = '0;
    ram_en_out    = 1'b0;
    ram_we_out    = 1'b0;
    ram_addr_out  = '0;
    ram_din_out   = '0;
    rd_tag        = '0;
    if (!rst_in) begin
      req_ready_out = grant;
    end
    xfer     = |req_ready_out;
    win_we   = req_we_in[win_idx];
    win_addr = `BPA_FIELD(req_addr_in, win_idx, ADDR_W);
    win_data = `BPA_FIELD(req_data_in, win_idx, DATA_W);
    if (xfer) begin
      ram_en_out   = 1'b1;
      ram_we_out   = win_we;
      ram_addr_out = win_addr;
      ram_din_out  = win_data;
      if (!win_we) begin
        rd_tag = req_ready_out;
      end
    end
  end

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      last_grant <= IDX_W'(N_REQ - 1);
    end else if (xfer) begin
      last_grant <= win_idx;
    end
  end

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      ram_regce_out <= 1'b0;
    end else begin
      ram_regce_out <= 1'b1;
    end
  end

  // Read tags travel alongside the RAM pipeline; writes insert an empty slot.
  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      for (int unsigned i = 0; i < READ_LATENCY; i++) begin
        tag_pipe[i] <= '0;
      end
    end else begin
      tag_pipe[0] <= rd_tag;
      for (int unsigned i = 1; i < READ_LATENCY; i++) begin
        tag_pipe[i] <= tag_pipe[i-1];
      end
    end
  end

  assign rsp_valid_out = tag_pipe[READ_LATENCY-1];
  assign rsp_data_out  = ram_dout_in;

endmodule

// File: tb/tb_bram_port_arbiter.sv
// Randomized bench for bram_port_arbiter against a round-robin/shadow-memory model.
module tb_bram_port_arbiter;

  localparam int N   = 4;
  localparam int DW  = 18;
  localparam int AW  = 10;
  localparam int LAT = 2;

  logic            clk;
  logic            rst;
  logic [N-1:0]    req_valid;
  logic [N-1:0]    req_we;
  logic [N*AW-1:0] req_addr;
  logic [N*DW-1:0] req_data;
  logic [N-1:0]    req_ready;
  logic [N-1:0]    rsp_valid;
  logic [DW-1:0]   rsp_data;
  logic            ram_en;
  logic            ram_we;
  logic [AW-1:0]   ram_addr;
  logic [DW-1:0]   ram_din;
  logic            ram_regce;
  logic [DW-1:0]   ram_dout;

  bram_port_arbiter #(
    .N_REQ        (N),
    .DATA_W       (DW),
    .ADDR_W       (AW),
    .READ_LATENCY (LAT)
  ) dut (
    .clk_in        (clk),
    .rst_in        (rst),
    .req_valid_in  (req_valid),
    .req_we_in     (req_we),
    .req_addr_in   (req_addr),
    .req_data_in   (req_data),
    .req_ready_out (req_ready),
    .rsp_valid_out (rsp_valid),
    .rsp_data_out  (rsp_data),
    .ram_en_out    (ram_en),
    .ram_we_out    (ram_we),
    .ram_addr_out  (ram_addr),
    .ram_din_out   (ram_din),
    .ram_regce_out (ram_regce),
    .ram_dout_in   (ram_dout)
  );

  // Read-first BRAM with an output register (two-cycle read latency).
  logic [DW-1:0] mem [1 << AW];
  logic [DW-1:0] ram_s1;
  always @(posedge clk) begin
    if (ram_en) begin
      if (ram_we) mem[ram_addr] <= ram_din;
      ram_s1 <= mem[ram_addr];
    end
    if (ram_regce) ram_dout <= ram_s1;
  end

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    int            due;
    logic [N-1:0]  tag;
    logic [DW-1:0] data;
    bit            chk;
  } exp_t;

  exp_t            exp_q[$];
  logic [DW-1:0]   shadow[int];
  int              ptr;
  int              cyc;
  int              since_rst;
  int              wait_cnt[N];
  int              n_tests;
  int              n_fail;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  function automatic logic [N*AW-1:0] one_a(input int i, input logic [AW-1:0] x);
    logic [N*AW-1:0] r;
    r = '0;
    r[i*AW +: AW] = x;
    return r;
  endfunction

  function automatic logic [N*DW-1:0] one_d(input int i, input logic [DW-1:0] x);
    logic [N*DW-1:0] r;
    r = '0;
    r[i*DW +: DW] = x;
    return r;
  endfunction

  // Drive one cycle, compare against the model mid-cycle, then advance.
  task automatic step(input logic [N-1:0] v, input logic [N-1:0] we,
                      input logic [N*AW-1:0] a, input logic [N*DW-1:0] d,
                      output int gidx);
    int            widx;
    int            c;
    exp_t          e;
    logic [N-1:0]  exp_tag;
    logic [DW-1:0] exp_dat;
    bit            dchk;
    logic [AW-1:0] wa;
    logic [DW-1:0] wd;
    req_valid = v;
    req_we    = we;
    req_addr  = a;
    req_data  = d;
    #4;
    widx = -1;
    for (int k = 1; k <= N; k++) begin
      c = (ptr + k) % N;
      if (widx < 0 && v[2'(c)]) widx = c;
    end
    check_eq("grant", 32'(req_ready), (widx >= 0) ? (32'd1 << widx) : 32'd0);
    check_eq("ram_en", 32'(ram_en), 32'(widx >= 0));
    wa = '0;
    wd = '0;
    if (widx >= 0) begin
      wa = a[widx*AW +: AW];
      wd = d[widx*DW +: DW];
      check_eq("ram_we", 32'(ram_we), 32'(we[2'(widx)]));
      check_eq("ram_addr", 32'(ram_addr), 32'(wa));
      if (we[2'(widx)]) check_eq("ram_din", 32'(ram_din), 32'(wd));
    end
    if (since_rst > 0) check_eq("regce", 32'(ram_regce), 32'd1);
    exp_tag = '0;
    exp_dat = '0;
    dchk    = 1'b0;
    if (exp_q.size() > 0 && exp_q[0].due == cyc) begin
      e       = exp_q.pop_front();
      exp_tag = e.tag;
      exp_dat = e.data;
      dchk    = e.chk;
    end
    check_eq("rsp_valid", 32'(rsp_valid), 32'(exp_tag));
    if (dchk) check_eq("rsp_data", 32'(rsp_data), 32'(exp_dat));
    for (int i = 0; i < N; i++) begin
      if (!v[2'(i)]) wait_cnt[i] = 0;
      else if (i == widx) begin
        check_eq("fairness", 32'(wait_cnt[i] < N), 32'd1);
        wait_cnt[i] = 0;
      end else wait_cnt[i]++;
    end
    if (widx >= 0) begin
      ptr = widx;
      if (we[2'(widx)]) shadow[int'(wa)] = wd;
      else begin
        e.due  = cyc + LAT;
        e.tag  = N'(1) << widx;
        e.chk  = shadow.exists(int'(wa));
        e.data = e.chk ? shadow[int'(wa)] : '0;
        exp_q.push_back(e);
      end
    end
    cyc++;
    since_rst++;
    gidx = widx;
    @(posedge clk);
    #1;
  endtask

  // Assert reset mid-cycle, check outputs immediately, hold it across one edge.
  task automatic reset_mid_cycle();
    #2 rst = 1'b1;
    #1;
    check_eq("rst_ready", 32'(req_ready), 32'd0);
    check_eq("rst_en", 32'(ram_en), 32'd0);
    check_eq("rst_we", 32'(ram_we), 32'd0);
    check_eq("rst_addr", 32'(ram_addr), 32'd0);
    check_eq("rst_din", 32'(ram_din), 32'd0);
    check_eq("rst_rsp", 32'(rsp_valid), 32'd0);
    check_eq("rst_regce", 32'(ram_regce), 32'd0);
    @(posedge clk);
    #1 rst = 1'b0;
    exp_q.delete();
    ptr       = N - 1;
    since_rst = 0;
    for (int i = 0; i < N; i++) wait_cnt[i] = 0;
  endtask

  logic [N-1:0]    pv, pw;
  logic [N*AW-1:0] pa, all_a;
  logic [N*DW-1:0] pd;
  int              g;

  initial begin
    n_tests = 0;
    n_fail  = 0;
    cyc     = 0;
    ptr     = N - 1;
    since_rst = 0;
    for (int i = 0; i < N; i++) wait_cnt[i] = 0;
    rst = 1'b0;
    req_valid = '0;
    req_we    = '0;
    req_addr  = '0;
    req_data  = '0;
    all_a = {10'h3FF, 10'h005, 10'h3FF, 10'h005};

    @(posedge clk);
    #1 req_valid = '1;
    reset_mid_cycle();

    // First grant after reset goes to requester 0.
    step(4'hF, 4'h0, all_a, '0, g);
    step(4'h0, 4'h0, '0, '0, g);
    step(4'h0, 4'h0, '0, '0, g);

    // Single reader on requester 2.
    step(4'b0100, 4'b0100, one_a(2, 10'h005), one_d(2, 18'h1ABCD), g);
    step(4'b0100, 4'b0000, one_a(2, 10'h005), '0, g);
    repeat (3) step(4'h0, 4'h0, '0, '0, g);

    // Write then read of the same address from different requesters.
    step(4'b0010, 4'b0010, one_a(1, 10'h3FF), one_d(1, 18'h00123), g);
    step(4'b1000, 4'b0000, one_a(3, 10'h3FF), '0, g);
    repeat (3) step(4'h0, 4'h0, '0, '0, g);

    // Sparse requesters 0 and 3 from last_grant=2, then idle, then all valid.
    step(4'b0100, 4'b0000, one_a(2, 10'h005), '0, g);
    repeat (4) step(4'b1001, 4'b0000, all_a, '0, g);
    repeat (2) step(4'h0, 4'h0, '0, '0, g);
    step(4'hF, 4'h0, all_a, '0, g);

    // Full rotation with all requesters valid.
    repeat (8) step(4'hF, 4'h0, all_a, '0, g);
    repeat (3) step(4'h0, 4'h0, '0, '0, g);

    // Reset while two reads are in flight.
    step(4'b0001, 4'b0000, one_a(0, 10'h005), '0, g);
    req_valid = 4'b0010;
    req_we    = 4'b0000;
    req_addr  = one_a(1, 10'h3FF);
    reset_mid_cycle();
    repeat (4) step(4'h0, 4'h0, '0, '0, g);
    step(4'hF, 4'h0, all_a, '0, g);
    repeat (3) step(4'h0, 4'h0, '0, '0, g);

    // Randomized traffic honouring the hold-until-granted rule.
    pv = '0; pw = '0; pa = '0; pd = '0;
    for (int n = 0; n < 1500; n++) begin
      for (int i = 0; i < N; i++) begin
        if (!pv[2'(i)] && $urandom_range(0, 1) == 1) begin
          pv[2'(i)]       = 1'b1;
          pw[2'(i)]       = ($urandom_range(0, 3) == 0);
          pa[i*AW +: AW]  = AW'($urandom_range(0, 15));
          pd[i*DW +: DW]  = DW'($urandom);
        end
      end
      step(pv, pw, pa, pd, g);
      if (g >= 0) pv[2'(g)] = 1'b0;
    end
    repeat (4) step(4'h0, 4'h0, '0, '0, g);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/bram_port_arbiter.md
# bram_port_arbiter

Round-robin arbiter that shares one port of a single-clock, read-first block RAM among `N_REQ` requesters. Each requester uses a valid/ready handshake. The arbiter drives the RAM port directly and tracks the fixed read latency with a tag pipeline, so each read response is steered back to the requester that issued it. It sits between the pixel/audio/control clients and the frame or sample buffer BRAM, which holds `RAM_DEPTH` words.

## Interface
- `N_REQ`, default 4: number of requesters (2..8).
- `DATA_W`, default 18: RAM word width.
- `ADDR_W`, default 10: RAM address width.
- `READ_LATENCY`, default 2: RAM read latency in cycles (1 = LOW_LATENCY, 2 = HIGH_PERFORMANCE).

Ports (clock and reset first):
- `clk_in`  in  1  system clock; also clocks the RAM.
- `rst_in`  in  1  asynchronous, active-high reset.
- `req_valid_in`  in  N_REQ  request pending, one bit per requester.
- `req_we_in`  in  N_REQ  1 = write, 0 = read.
- `req_addr_in`  in  N_REQ*ADDR_W  packed addresses; requester i at `[i*ADDR_W +: ADDR_W]`.
- `req_data_in`  in  N_REQ*DATA_W  packed write data; same packing.
- `req_ready_out`  out  N_REQ  one-hot grant, combinational.
- `rsp_valid_out`  out  N_REQ  one-hot read-data strobe.
- `rsp_data_out`  out  DATA_W  read data, shared by all requesters.
- `ram_en_out`  out  1  RAM port enable.
- `ram_we_out`  out  1  RAM write enable.
- `ram_addr_out`  out  ADDR_W  RAM address.
- `ram_din_out`  out  DATA_W  RAM write data.
- `ram_regce_out`  out  1  RAM output register enable; constant 1 out of reset.
- `ram_dout_in`  in  DATA_W  RAM read data.

## Operation
- Transfer for requester i occurs when `req_valid_in[i] && req_ready_out[i]`. At most one transfer per cycle.
- Grant selection is round-robin. Search starts at `last_grant+1` modulo `N_REQ`; the first requester with valid set wins.
- `last_grant` updates only on a transfer. It resets to `N_REQ-1`, so requester 0 has first priority after reset.
- No valid inputs means:
  - `req_ready_out` = 0;
  - `ram_en_out` = 0;
  - `last_grant` is unchanged.
- On a granted request, the `ram_*` outputs mux the winner's `we`, `addr` and `data` onto the RAM port in the same cycle, with `ram_en_out` = 1.
- Writes produce no response. The read-first old data the RAM returns on a write is discarded.
- Reads push a one-hot tag of the winner into a `READ_LATENCY`-deep shift register.
  - `rsp_valid_out` = tag at the tail of the shift register.
  - `rsp_data_out` = `ram_dout_in` passed through unregistered.
- Responses have no backpressure. Requesters must accept `rsp_valid_out` when it is asserted.
- Fairness: a requester holding valid is granted within `N_REQ` cycles.
- Requesters must hold `addr`, `data` and `we` stable while valid is set and not yet granted.

## Timing
- Reset values:
  - `req_ready_out` = 0 while `rst_in` is high;
  - `rsp_valid_out` = 0;
  - `ram_en_out` = `ram_we_out` = 0;
  - `ram_addr_out` and `ram_din_out` = 0;
  - `ram_regce_out` = 0 during reset, 1 after;
  - tag pipeline cleared.
- Grant is combinational from `req_valid_in` and `last_grant`. The request is presented to the RAM in cycle t.
- Read response latency: `rsp_valid_out` is asserted in cycle t+READ_LATENCY for exactly one cycle.
- Throughput: one access per cycle, sustained.
- Write in cycle t followed by a read of the same address in cycle t+1 returns the new data. The RAM commits the write at the edge that ends cycle t.
- Reset mid-operation: in-flight reads are dropped, no `rsp_valid_out` is issued for them, and the pointer returns to `N_REQ-1`.

## Structure
- Shared package/header holds:
  - `BRAM_LAT_LOW` = 1 and `BRAM_LAT_HIGH` = 2;
  - the address/data packing macros.
- Sub-module `rr_priority_picker`: combinational. Inputs are `N_REQ` request bits and the `last_grant` index; outputs are the one-hot grant and its binary index.
- The top level holds:
  - `last_grant` register;
  - request mux;
  - tag shift register.

## Test plan
Defaults for all scenarios: `N_REQ`=4, `DATA_W`=18, `ADDR_W`=10, `READ_LATENCY`=2, RAM model attached.
- **Reset:** assert `rst_in` asynchronously mid-cycle → all outputs listed above go to their reset values immediately. First grant after release goes to requester 0 when all four are valid.
- **Single reader:** requester 2 reads addr 0x05 holding 0x1ABCD → `req_ready_out`=4'b0100 in cycle t; `rsp_valid_out`=4'b0100 with `rsp_data_out`=0x1ABCD in cycle t+2.
- **Rotation:** all four valid continuously for 8 cycles → grants 0,1,2,3,0,1,2,3. Response tags follow the same order, two cycles behind.
- **Write then read:**
  - requester 1 writes 0x00123 to addr 0x3FF in cycle t;
  - requester 3 reads 0x3FF in cycle t+1;
  - expected: `rsp_data_out`=0x00123 in cycle t+3 with `rsp_valid_out`=4'b1000, and no response ever issued for the write.
- **Sparse and idle:**
  - requesters 0 and 3 valid → alternating grants 3,0,3,0 starting from `last_grant`=2;
  - all valid low → `ram_en_out`=0 and pointer unchanged.
- **Reset mid-read:**
  - reads issued in cycles t and t+1;
  - `rst_in` pulsed in cycle t+1;
  - expected: `rsp_valid_out` never asserts for either read.
